// File: rtl/bridge_drv.sv
// Full-bridge gate drive: converts burst enable and resonant phase into two
// complementary outputs with dead time, soft stop, max-on, watchdog and over-current latch.
module bridge_drv #(
    parameter int unsigned DT_CYC = 4,
    parameter int unsigned MAX_ON = 2000,
    parameter int unsigned WDOG   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       phase,
    input  logic       ocd,
    output logic       out_p,
    output logic       out_n,
    output logic       fault,
    output logic [7:0] half_cnt
);

    localparam int unsigned DT_W  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned HC_W  = 8;

    localparam logic [DT_W-1:0]  DT_LAST  = DT_W'(DT_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_ON_C = CNT_W'(MAX_ON);
    localparam logic [CNT_W-1:0] WDOG_C   = CNT_W'(WDOG);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [HC_W-1:0]  HC_SAT   = '1;

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        DRIVE_P,
        DRIVE_N,
        FAULT
    } state_e;

    // Two-flop synchronizers plus one delayed phase copy for edge detection
    logic en_m_q, en_s_q;
    logic ph_m_q, ph_s_q, ph_d1_q;
    logic ocd_m_q, ocd_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_m_q  <= 1'b0;
            en_s_q  <= 1'b0;
            ph_m_q  <= 1'b0;
            ph_s_q  <= 1'b0;
            ph_d1_q <= 1'b0;
            ocd_m_q <= 1'b0;
            ocd_s_q <= 1'b0;
        end else begin
            en_m_q  <= en;
            en_s_q  <= en_m_q;
            ph_m_q  <= phase;
            ph_s_q  <= ph_m_q;
            ph_d1_q <= ph_s_q;
            ocd_m_q <= ocd;
            ocd_s_q <= ocd_m_q;
        end
    end

    state_e            state_q, state_d;
    logic [DT_W-1:0]   dt_cnt_q, dt_cnt_d;
    logic [CNT_W-1:0]  on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic [HC_W-1:0]   half_int_q, half_int_d;
    logic [HC_W-1:0]   half_cnt_q, half_cnt_d;
    logic              out_p_q, out_p_d;
    logic              out_n_q, out_n_d;
    logic              fault_q, fault_d;

    logic              phase_edge;
    logic              stop_pend;
    logic [CNT_W-1:0]  on_inc;
    logic [CNT_W-1:0]  wd_inc;
    logic [HC_W-1:0]   half_inc;

    always_comb begin
        phase_edge = ph_s_q ^ ph_d1_q;
        stop_pend  = !en_s_q || (on_cnt_q >= MAX_ON_C);
        on_inc     = (on_cnt_q == CNT_SAT) ? on_cnt_q : on_cnt_q + CNT_W'(1);
        // A phase edge restarts the watchdog window, so it can never fire on an edge
        wd_inc     = phase_edge ? '0
                   : ((wd_cnt_q == CNT_SAT) ? wd_cnt_q : wd_cnt_q + CNT_W'(1));
        half_inc   = (half_int_q == HC_SAT) ? half_int_q : half_int_q + HC_W'(1);

        state_d    = state_q;
        dt_cnt_d   = dt_cnt_q;
        on_cnt_d   = on_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        half_int_d = half_int_q;
        half_cnt_d = half_cnt_q;

        case (state_q)
            IDLE: begin
                dt_cnt_d   = '0;
                on_cnt_d   = '0;
                wd_cnt_d   = '0;
                half_int_d = '0;
                if (en_s_q && phase_edge) begin
                    state_d = DEAD;
                end
            end

            DEAD: begin
                on_cnt_d = on_inc;
                wd_cnt_d = wd_inc;
                if (ocd_s_q) begin
                    state_d = FAULT;
                end else if (wd_inc >= WDOG_C) begin
                    state_d    = IDLE;
                    half_cnt_d = half_int_q;
                end else if (phase_edge) begin
                    dt_cnt_d = '0;
                end else if (dt_cnt_q == DT_LAST) begin
                    state_d = ph_s_q ? DRIVE_P : DRIVE_N;
                end else begin
                    dt_cnt_d = dt_cnt_q + DT_W'(1);
                end
            end

            DRIVE_P, DRIVE_N: begin
                on_cnt_d = on_inc;
                wd_cnt_d = wd_inc;
                if (ocd_s_q) begin
                    state_d = FAULT;
                end else if (wd_inc >= WDOG_C) begin
                    state_d    = IDLE;
                    half_cnt_d = half_int_q;
                end else if (phase_edge) begin
                    half_int_d = half_inc;
                    dt_cnt_d   = '0;
                    if (stop_pend) begin
                        state_d    = IDLE;
                        half_cnt_d = half_inc;
                    end else begin
                        state_d = DEAD;
                    end
                end
            end

            FAULT: begin
                if (!en_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_p_d = (state_d == DRIVE_P);
        out_n_d = (state_d == DRIVE_N);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dt_cnt_q   <= '0;
            on_cnt_q   <= '0;
            wd_cnt_q   <= '0;
            half_int_q <= '0;
            half_cnt_q <= '0;
            out_p_q    <= 1'b0;
            out_n_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dt_cnt_q   <= dt_cnt_d;
            on_cnt_q   <= on_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            half_int_q <= half_int_d;
            half_cnt_q <= half_cnt_d;
            out_p_q    <= out_p_d;
            out_n_q    <= out_n_d;
            fault_q    <= fault_d;
        end
    end

    assign out_p    = out_p_q;
    assign out_n    = out_n_q;
    assign fault    = fault_q;
    assign half_cnt = half_cnt_q;

    // Both bridge diagonals on at once would short the supply
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(out_p_q && out_n_q));

endmodule

// File: tb/tb_bridge_drv.sv
// Directed bench for bridge_drv: vector table for a normal burst plus
// hand-written sequences for glitch, over-current, watchdog, max-on, saturation and reset.
module tb_bridge_drv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ph  = 1'b0;
    logic       oc  = 1'b0;

    logic       a_p, a_n, a_f;
    logic [7:0] a_h;
    logic       b_p, b_n, b_f;
    logic [7:0] b_h;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bridge_drv #(.DT_CYC(4), .MAX_ON(65535), .WDOG(200)) dut_a (
        .clk(clk), .rst(rst), .en(en), .phase(ph), .ocd(oc),
        .out_p(a_p), .out_n(a_n), .fault(a_f), .half_cnt(a_h)
    );

    bridge_drv #(.DT_CYC(4), .MAX_ON(100), .WDOG(200)) dut_b (
        .clk(clk), .rst(rst), .en(en), .phase(ph), .ocd(oc),
        .out_p(b_p), .out_n(b_n), .fault(b_f), .half_cnt(b_h)
    );

    typedef struct {
        logic        i_en;
        logic        i_ph;
        logic        i_ocd;
        int unsigned wait_n;
        logic        e_p;
        logic        e_n;
        logic        e_f;
        logic        c_h;
        logic [7:0]  e_h;
    } vec_t;

    vec_t vecs[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic e, input logic p, input logic o, input int unsigned w,
                       input logic xp, input logic xn, input logic xf,
                       input logic ch, input logic [7:0] xh);
        vecs.push_back('{e, p, o, w, xp, xn, xf, ch, xh});
    endtask

    // Never both diagonals on, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            n_total++;
            if (!(a_p && a_n) && !(b_p && b_n)) n_pass++;
            else $display("FAIL overlap: a=%b%b b=%b%b expected no overlap", a_p, a_n, b_p, b_n);
        end
    end

    initial begin
        // Normal burst: 40-cycle phase period, en dropped together with the 20th drive edge
        add(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        for (int j = 0; j < 20; j++) begin
            logic cp, pp, pn;
            cp = (j % 2 == 0);
            pp = (j % 2 == 1);
            pn = (j % 2 == 0) && (j > 0);
            add(1'b1, cp, 1'b0, 2,  pp,  pn,  1'b0, 1'b0, 8'd0);
            add(1'b1, cp, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            add(1'b1, cp, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            add(1'b1, cp, 1'b0, 1,  cp,  !cp, 1'b0, 1'b0, 8'd0);
            add(1'b1, cp, 1'b0, 13, cp,  !cp, 1'b0, 1'b1, 8'd0);
        end
        add(1'b0, 1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        add(1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b1, 8'd20);
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b1, 8'd20);

        // Reset state
        tick(3);
        chk("rst_hold_p", a_p, 0);
        chk("rst_hold_n", a_n, 0);
        chk("rst_hold_f", a_f, 0);
        chk("rst_hold_h", a_h, 0);
        rst = 1'b0;
        tick(5);
        chk("rst_rel_p", a_p, 0);
        chk("rst_rel_n", a_n, 0);
        chk("rst_rel_h", a_h, 0);

        foreach (vecs[i]) begin
            en = vecs[i].i_en;
            ph = vecs[i].i_ph;
            oc = vecs[i].i_ocd;
            tick(int'(vecs[i].wait_n));
            chk($sformatf("vec%0d_p", i), a_p, int'(vecs[i].e_p));
            chk($sformatf("vec%0d_n", i), a_n, int'(vecs[i].e_n));
            chk($sformatf("vec%0d_f", i), a_f, int'(vecs[i].e_f));
            if (vecs[i].c_h) chk($sformatf("vec%0d_h", i), a_h, int'(vecs[i].e_h));
        end

        // Dead-time glitch: 2-cycle high pulse inside an N half-cycle
        en = 1'b1;
        tick(5);
        ph = 1'b0;
        tick(7);
        chk("glitch_pre_n", a_n, 1);
        tick(3);
        ph = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            chk($sformatf("glitch%0d_p", i), a_p, 0);
            chk($sformatf("glitch%0d_n", i), a_n, (i < 3 || i == 9) ? 1 : 0);
            if (i == 2) ph = 1'b0;
        end
        tick(10);
        chk("glitch_hold_n", a_n, 1);
        en = 1'b0;
        ph = 1'b1;
        tick(2);
        chk("glitch_stop_n2", a_n, 1);
        tick(1);
        chk("glitch_stop_n3", a_n, 0);
        chk("glitch_stop_h", a_h, 2);
        tick(5);
        chk("glitch_idle_p", a_p, 0);

        // Over-current: ignored in IDLE, latched during DRIVE_N
        oc = 1'b1;
        tick(5);
        chk("ocd_idle_f", a_f, 0);
        oc = 1'b0;
        tick(5);
        en = 1'b1;
        tick(5);
        ph = 1'b0;
        tick(10);
        chk("ocd_pre_n", a_n, 1);
        oc = 1'b1;
        tick(2);
        chk("ocd_2_n", a_n, 1);
        chk("ocd_2_f", a_f, 0);
        tick(1);
        chk("ocd_3_n", a_n, 0);
        chk("ocd_3_f", a_f, 1);
        oc = 1'b0;
        tick(10);
        chk("ocd_hold_f", a_f, 1);
        ph = 1'b1;
        tick(10);
        chk("ocd_edge_p", a_p, 0);
        chk("ocd_edge_f", a_f, 1);
        en = 1'b0;
        tick(2);
        chk("ocd_clr2_f", a_f, 1);
        tick(1);
        chk("ocd_clr3_f", a_f, 0);
        chk("ocd_h", a_h, 2);

        // Watchdog: phase frozen high after one counted edge
        en = 1'b1;
        tick(5);
        ph = 1'b0;
        tick(20);
        ph = 1'b1;
        tick(202);
        chk("wdog_202_p", a_p, 1);
        tick(1);
        chk("wdog_203_p", a_p, 0);
        chk("wdog_h", a_h, 1);
        tick(20);
        chk("wdog_idle_p", a_p, 0);
        chk("wdog_idle_n", a_n, 0);
        en = 1'b0;
        tick(250);

        // Max-on on the MAX_ON=100 instance, continuous en
        en = 1'b1;
        tick(5);
        ph = 1'b0;
        for (int t = 1; t <= 130; t++) begin
            tick(1);
            case (t)
                103: begin chk("maxon_103_p", b_p, 0); chk("maxon_103_n", b_n, 0); end
                107: chk("maxon_107_p", b_p, 1);
                122: chk("maxon_122_p", b_p, 1);
                123: begin
                    chk("maxon_123_p", b_p, 0);
                    chk("maxon_123_n", b_n, 0);
                    chk("maxon_h", b_h, 6);
                end
                127: begin chk("maxon_127_p", b_p, 0); chk("maxon_127_n", b_n, 0); end
                default: ;
            endcase
            if (t % 20 == 0 && t <= 120) ph = ~ph;
        end
        en = 1'b0;
        tick(250);

        // Saturation: 300 counted half-cycles, half period 10
        en = 1'b1;
        tick(5);
        for (int k = 0; k <= 300; k++) begin
            ph = ~ph;
            if (k == 300) en = 1'b0;
            tick(10);
        end
        chk("sat_h", a_h, 255);
        chk("sat_p", a_p, 0);
        chk("sat_n", a_n, 0);

        // Asynchronous reset mid-burst
        ph = 1'b0;
        tick(5);
        en = 1'b1;
        tick(5);
        ph = 1'b1;
        tick(7);
        chk("rstmid_pre_p", a_p, 1);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_async_p", a_p, 0);
        chk("rstmid_async_h", a_h, 0);
        tick(2);
        en = 1'b0;
        rst = 1'b0;
        tick(5);
        chk("rstmid_rel_p", a_p, 0);
        chk("rstmid_rel_n", a_n, 0);
        chk("rstmid_rel_f", a_f, 0);
        chk("rstmid_rel_h", a_h, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
